// File: rtl/vga_line_fetcher_if.sv
// Burst port between the SRAM driver and the VGA line fetcher.
// The fetcher is the master: it raises a 4-phase request with a start address and length,
// and the driver streams words back and acknowledges completion.
interface vga_line_fetcher_if;
  logic        vga_burst_req;
  logic        vga_burst_ack;
  logic [18:0] vga_burst_addr;
  logic [8:0]  vga_burst_len;
  logic        vga_wdata_valid;
  logic [15:0] vga_wdata;

  modport master (
    output vga_burst_req,
    output vga_burst_addr,
    output vga_burst_len,
    input  vga_burst_ack,
    input  vga_wdata_valid,
    input  vga_wdata
  );

  modport slave (
    input  vga_burst_req,
    input  vga_burst_addr,
    input  vga_burst_len,
    output vga_burst_ack,
    output vga_wdata_valid,
    output vga_wdata
  );
endinterface

// File: rtl/vga_line_fetcher.sv
// Scanline fetcher: pulls one framebuffer line per SRAM burst into the back half of a
// ping-pong line buffer while the scanout logic reads pixels from the front half.
module vga_line_fetcher #(
  parameter logic [18:0] FB_BASE    = 19'h00000,
  parameter int unsigned LINE_WORDS = 320,
  parameter int unsigned LINES      = 240
) (
  input  logic                clk_50mhz,
  input  logic                resetn,
  input  logic                enable,
  input  logic                frame_start,
  input  logic                line_swap,
  input  logic [8:0]          rd_addr,
  output logic [15:0]         rd_data,
  vga_line_fetcher_if.master  burst,
  output logic                line_ready,
  output logic                fetch_busy,
  output logic                underrun
);

  localparam int unsigned Depth = 2 * LINE_WORDS;
  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(LINES + 1);

  localparam logic [8:0]       LenWords = 9'(LINE_WORDS);
  localparam logic [18:0]      LineStep = 19'(LINE_WORDS);
  localparam logic [CntW-1:0]  LinesMax = CntW'(LINES);
  localparam logic [AddrW-1:0] HalfOff  = AddrW'(LINE_WORDS);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StReq     = 2'd1;
  localparam logic [1:0] StWaitLow = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            req_q, req_d;
  logic [18:0]     burst_addr_q, burst_addr_d;
  logic [18:0]     next_addr_q, next_addr_d;
  logic [8:0]      wr_idx_q, wr_idx_d;
  logic            fb_sel_q, fb_sel_d;
  logic [CntW-1:0] line_cnt_q, line_cnt_d;
  logic [CntW-1:0] line_cnt_inc;
  logic            need_fetch_q, need_fetch_d;
  logic            restart_pending_q, restart_pending_d;
  logic            line_ready_q, line_ready_d;
  logic            underrun_q, underrun_d;
  logic [15:0]     rd_data_q, rd_data_d;

  logic [15:0]      mem [Depth];
  logic             wr_en;
  logic [AddrW-1:0] wr_ptr;
  logic [AddrW-1:0] rd_ptr;

  // Buffer halves are laid out back to back; fb_sel picks which half is the front.
  assign rd_ptr = (fb_sel_q ? HalfOff : '0) + AddrW'(rd_addr);
  assign wr_ptr = (fb_sel_q ? '0 : HalfOff) + AddrW'(wr_idx_q);

  // Burst FSM plus frame/line bookkeeping; frame_start overrides line_swap.
  always_comb begin
    state_d           = state_q;
    req_d             = req_q;
    burst_addr_d      = burst_addr_q;
    next_addr_d       = next_addr_q;
    wr_idx_d          = wr_idx_q;
    fb_sel_d          = fb_sel_q;
    line_cnt_d        = line_cnt_q;
    need_fetch_d      = need_fetch_q;
    restart_pending_d = restart_pending_q;
    line_ready_d      = line_ready_q;
    underrun_d        = underrun_q;
    wr_en             = 1'b0;
    line_cnt_inc      = line_cnt_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        // A same-cycle frame_start defers the launch so the burst uses the reset address.
        if (enable && need_fetch_q && !burst.vga_burst_ack && !frame_start) begin
          req_d        = 1'b1;
          burst_addr_d = next_addr_q;
          wr_idx_d     = '0;
          state_d      = StReq;
        end
      end
      StReq: begin
        if (burst.vga_wdata_valid && (wr_idx_q < LenWords)) begin
          wr_en    = 1'b1;
          wr_idx_d = wr_idx_q + 1'b1;
        end
        if (burst.vga_burst_ack) begin
          req_d   = 1'b0;
          state_d = StWaitLow;
        end
      end
      StWaitLow: begin
        // The final word may trail the ack by a cycle.
        if (burst.vga_wdata_valid && (wr_idx_q < LenWords)) begin
          wr_en    = 1'b1;
          wr_idx_d = wr_idx_q + 1'b1;
        end
        if (!burst.vga_burst_ack) begin
          state_d           = StIdle;
          restart_pending_d = 1'b0;
          // A restarted fetch keeps need_fetch set so line 0 is fetched again.
          if (!restart_pending_q) begin
            need_fetch_d = 1'b0;
            line_ready_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase

    if (frame_start) begin
      line_cnt_d        = '0;
      next_addr_d       = FB_BASE;
      line_ready_d      = 1'b0;
      need_fetch_d      = 1'b1;
      restart_pending_d = (state_d != StIdle);
    end else if (line_swap) begin
      if (line_ready_q) begin
        fb_sel_d     = ~fb_sel_q;
        line_ready_d = 1'b0;
        line_cnt_d   = line_cnt_inc;
        if (line_cnt_inc < LinesMax) begin
          need_fetch_d = 1'b1;
          next_addr_d  = next_addr_q + LineStep;
        end
      end else begin
        underrun_d = 1'b1;
      end
    end
  end

  // Front-buffer read, one cycle of latency.
  always_comb begin
    rd_data_d = mem[rd_ptr];
  end

  // Control state registers.
  always_ff @(posedge clk_50mhz or negedge resetn) begin
    if (!resetn) begin
      state_q           <= StIdle;
      req_q             <= 1'b0;
      burst_addr_q      <= FB_BASE;
      next_addr_q       <= FB_BASE;
      wr_idx_q          <= '0;
      fb_sel_q          <= 1'b0;
      line_cnt_q        <= '0;
      need_fetch_q      <= 1'b0;
      restart_pending_q <= 1'b0;
      line_ready_q      <= 1'b0;
      underrun_q        <= 1'b0;
      rd_data_q         <= '0;
    end else begin
      state_q           <= state_d;
      req_q             <= req_d;
      burst_addr_q      <= burst_addr_d;
      next_addr_q       <= next_addr_d;
      wr_idx_q          <= wr_idx_d;
      fb_sel_q          <= fb_sel_d;
      line_cnt_q        <= line_cnt_d;
      need_fetch_q      <= need_fetch_d;
      restart_pending_q <= restart_pending_d;
      line_ready_q      <= line_ready_d;
      underrun_q        <= underrun_d;
      rd_data_q         <= rd_data_d;
    end
  end

  // Line buffer storage; no reset so it maps onto block RAM.
  always_ff @(posedge clk_50mhz) begin
    if (wr_en) begin
      mem[wr_ptr] <= burst.vga_wdata;
    end
  end

  assign burst.vga_burst_req  = req_q;
  assign burst.vga_burst_addr = burst_addr_q;
  assign burst.vga_burst_len  = LenWords;
  assign rd_data              = rd_data_q;
  assign line_ready           = line_ready_q;
  assign fetch_busy           = (state_q != StIdle);
  assign underrun             = underrun_q;

endmodule
